// File: rtl/dj_score_pkg.sv
// Shared constants, types and helpers for the on-screen score display path.
package dj_score_pkg;

  localparam int SCORE_W = 20;
  localparam int DIGITS  = 6;
  localparam int ITER_W  = $clog2(SCORE_W);
  localparam logic [SCORE_W-1:0] SAT_MAX = SCORE_W'(999999);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} score_state_t;

  typedef logic [4*DIGITS-1:0] bcd_t;

  // A digit is blanked when it and every digit above it is zero; the units
  // digit is never blanked so a score of zero still shows a single "0".
  function automatic logic [DIGITS-1:0] blank_mask_of(input bcd_t bcd);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/score_bcd_display_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// combined {bcd, bin} register left by one bit.
module bcd_dabble_step
  import dj_score_pkg::*;
(
  input  bcd_t               bcd_in,
  input  logic [SCORE_W-1:0] bin_in,
  output bcd_t               bcd_out,
  output logic [SCORE_W-1:0] bin_out
);

  bcd_t                        adj;
  logic [4*DIGITS+SCORE_W-1:0] work;

  // Digits never exceed 9 between shifts, so the 4-bit add-3 cannot wrap.
  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
    work               = {adj, bin_in} << 1;
    {bcd_out, bin_out} = work;
  end

endmodule

// File: rtl/score_bcd_display.sv
// Per-frame score sampler: clamps Score, converts it to BCD with a sequential
// double-dabble engine, keeps a session high score and a leading-zero mask.
module score_bcd_display
  import dj_score_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic [SCORE_W-1:0]  Score,
  input  logic                hi_clear,
  output logic [4*DIGITS-1:0] bcd_digits,
  output logic [4*DIGITS-1:0] hi_digits,
  output logic [SCORE_W-1:0]  hi_score,
  output logic [DIGITS-1:0]   blank_mask,
  output logic                sat,
  output logic                busy,
  output logic                done
);

  score_state_t       state_q, state_d;
  logic               fv_q;
  logic               req;
  logic [SCORE_W-1:0] bin_q, val_q;
  bcd_t               bcd_q;
  logic               sat_work_q;
  logic [ITER_W-1:0]  iter_q;
  bcd_t               bcd_next;
  logic [SCORE_W-1:0] bin_next;
  logic               over;

  assign req  = frame_clk & ~fv_q;
  assign over = (Score > SAT_MAX);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  bcd_dabble_step u_step (
    .bcd_in  (bcd_q),
    .bin_in  (bin_q),
    .bcd_out (bcd_next),
    .bin_out (bin_next)
  );

  // State register and vsync edge-detect history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= frame_clk;
    end
  end

  // Next-state logic; requests outside IDLE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (iter_q == ITER_W'(SCORE_W-1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion work registers, kept apart from the visible outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_q      <= '0;
      val_q      <= '0;
      bcd_q      <= '0;
      sat_work_q <= 1'b0;
      iter_q     <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          bin_q      <= over ? SAT_MAX : Score;
          val_q      <= over ? SAT_MAX : Score;
          sat_work_q <= over;
          bcd_q      <= '0;
          iter_q     <= '0;
        end
        S_SHIFT: begin
          bcd_q  <= bcd_next;
          bin_q  <= bin_next;
          iter_q <= iter_q + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Visible score outputs change only on the DONE edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd_digits <= '0;
      sat        <= 1'b0;
      blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (state_q == S_DONE) begin
      bcd_digits <= bcd_q;
      sat        <= sat_work_q;
      blank_mask <= blank_mask_of(bcd_q);
    end
  end

  // High score tracking; a clear pulse overrides a coincident update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_score  <= '0;
      hi_digits <= '0;
    end else if (hi_clear) begin
      hi_score  <= '0;
      hi_digits <= '0;
    end else if ((state_q == S_DONE) && (val_q > hi_score)) begin
      hi_score  <= val_q;
      hi_digits <= bcd_q;
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench for score_bcd_display: table vectors, hand-written
// corner sequences and randomized scores against an arithmetic model.
module tb_score_bcd_display;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [19:0] Score;
  logic        hi_clear;
  logic [23:0] bcd_digits;
  logic [23:0] hi_digits;
  logic [19:0] hi_score;
  logic [5:0]  blank_mask;
  logic        sat;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  int unsigned model_hi = 0;

  typedef struct {
    logic [19:0] score;
    logic [23:0] exp_bcd;
    logic [5:0]  exp_mask;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[9];

  score_bcd_display dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .Score      (Score),
    .hi_clear   (hi_clear),
    .bcd_digits (bcd_digits),
    .hi_digits  (hi_digits),
    .hi_score   (hi_score),
    .blank_mask (blank_mask),
    .sat        (sat),
    .busy       (busy),
    .done       (done)
  );

  always #10 Clk = ~Clk;

  function automatic int unsigned clamp_of(input int unsigned v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic logic [23:0] model_bcd(input int unsigned v);
    logic [23:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_mask(input int unsigned v);
    logic [5:0]  m;
    int unsigned t;
    int          nd;
    if (v == 0) return 6'b111110;
    nd = 0;
    t  = v;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    m = '0;
    for (int i = nd; i < 6; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Starts a conversion and watches 40 cycles; optional second edge with a new
  // Score, optional hi_clear on the DONE cycle, Score scrambled after LOAD.
  task automatic applyStimulus(input logic [19:0] score, input int second_at,
                               input logic [19:0] second_score, input bit clear_at_done,
                               output int done_cycle, output int done_count, output int bad);
    logic [23:0] prev;
    done_cycle = -1;
    done_count = 0;
    bad        = 0;
    @(negedge Clk);
    prev      = bcd_digits;
    Score     = score;
    frame_clk = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      hi_clear = 1'b0;
      if (k == 1) frame_clk = 1'b0;
      if (k == 3 && second_at == 0) Score = 20'($urandom);
      if (k == second_at) begin
        Score     = second_score;
        frame_clk = 1'b1;
      end
      if (second_at > 0 && k == second_at + 1) frame_clk = 1'b0;
      if (k <= 22 && (busy !== 1'b1 || bcd_digits !== prev)) bad++;
      if (k == 23 && busy !== 1'b0) bad++;
      if (done === 1'b1) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle = k;
          if (clear_at_done) hi_clear = 1'b1;
        end
      end
    end
  endtask

  task automatic checkResult(input string name, input int unsigned score, input logic [23:0] exp_bcd,
                             input logic [5:0] exp_mask, input logic exp_sat, input bit cleared,
                             input int done_cycle, input int done_count, input int bad);
    int unsigned c;
    c = clamp_of(score);
    if (cleared) model_hi = 0;
    else if (c > model_hi) model_hi = c;
    checkOutput({name, " bcd"}, 32'(bcd_digits), 32'(exp_bcd));
    checkOutput({name, " mask"}, 32'(blank_mask), 32'(exp_mask));
    checkOutput({name, " sat"}, 32'(sat), 32'(exp_sat));
    checkOutput({name, " hi_score"}, 32'(hi_score), model_hi);
    checkOutput({name, " hi_digits"}, 32'(hi_digits), 32'(model_bcd(model_hi)));
    checkOutput({name, " done_cycle"}, 32'(done_cycle), 32'd22);
    checkOutput({name, " done_count"}, 32'(done_count), 32'd1);
    checkOutput({name, " busy/glitch"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int dc, dn, bad;
    int unsigned v;

    vecs[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0};
    vecs[1] = '{20'd12345,   24'h012345, 6'b100000, 1'b0};
    vecs[2] = '{20'hFFFFF,   24'h999999, 6'b000000, 1'b1};
    vecs[3] = '{20'd5,       24'h000005, 6'b111110, 1'b0};
    vecs[4] = '{20'd1000000, 24'h999999, 6'b000000, 1'b1};
    vecs[5] = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
    vecs[6] = '{20'd100000,  24'h100000, 6'b000000, 1'b0};
    vecs[7] = '{20'd10,      24'h000010, 6'b111100, 1'b0};
    vecs[8] = '{20'd987,     24'h000987, 6'b111000, 1'b0};

    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    Score     = '0;
    hi_clear  = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset bcd", 32'(bcd_digits), 32'h0);
    checkOutput("reset mask", 32'(blank_mask), 32'b111110);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset hi", 32'(hi_score), 32'h0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].score, 0, '0, 1'b0, dc, dn, bad);
      checkResult($sformatf("vec%0d", i), vecs[i].score, vecs[i].exp_bcd, vecs[i].exp_mask,
                  vecs[i].exp_sat, 1'b0, dc, dn, bad);
    end

    @(negedge Clk);
    hi_clear = 1'b1;
    @(negedge Clk);
    hi_clear = 1'b0;
    model_hi = 0;
    checkOutput("idle clear hi", 32'(hi_score), 32'h0);
    checkOutput("idle clear digits", 32'(hi_digits), 32'h0);

    applyStimulus(20'd500, 10, 20'd300, 1'b0, dc, dn, bad);
    checkResult("dropped req", 500, 24'h000500, 6'b111000, 1'b0, 1'b0, dc, dn, bad);

    applyStimulus(20'd800, 0, '0, 1'b1, dc, dn, bad);
    checkResult("clear at done", 800, 24'h000800, 6'b111000, 1'b0, 1'b1, dc, dn, bad);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(999990, 1048575);
      else v = $urandom_range(0, 1048575);
      applyStimulus(20'(v), 0, '0, 1'b0, dc, dn, bad);
      checkResult($sformatf("rand%0d", r), v, model_bcd(clamp_of(v)), model_mask(clamp_of(v)),
                  v > 999999, 1'b0, dc, dn, bad);
      if ($urandom_range(0, 7) == 0) begin
        hi_clear = 1'b1;
        @(negedge Clk);
        hi_clear = 1'b0;
        model_hi = 0;
      end
    end

    applyStimulus(20'd4000, 0, '0, 1'b0, dc, dn, bad);
    checkResult("pre-abort", 4000, 24'h004000, 6'b110000, 1'b0, 1'b0, dc, dn, bad);
    @(negedge Clk);
    Score     = 20'd777;
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    checkOutput("abort in flight busy", 32'(busy), 32'h1);
    Reset_n = 1'b0;
    #1;
    checkOutput("abort bcd", 32'(bcd_digits), 32'h0);
    checkOutput("abort hi", 32'(hi_score), 32'h0);
    checkOutput("abort hi_digits", 32'(hi_digits), 32'h0);
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort mask", 32'(blank_mask), 32'b111110);
    checkOutput("abort sat", 32'(sat), 32'h0);
    @(negedge Clk);
    Reset_n  = 1'b1;
    model_hi = 0;
    repeat (2) @(negedge Clk);
    applyStimulus(20'd4321, 0, '0, 1'b0, dc, dn, bad);
    checkResult("post-abort", 4321, 24'h004321, 6'b110000, 1'b0, 1'b0, dc, dn, bad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
Downstream consumer of the game core's 20-bit binary Score. Once per video frame it samples Score and converts it to six BCD digits with a sequential double-dabble engine. It tracks a session high score and produces a leading-zero blank mask. Its outputs drive the HEX drivers and the colour mapper's on-screen score.

Parameters:
SCORE_W, 20, width of binary Score input; also the number of shift iterations.
DIGITS, 6, number of BCD output digits.
SAT_MAX, 999999, largest displayable value; inputs above it are clamped.

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  VGA vertical sync level, synchronous to Clk; a rising edge requests a conversion
Score  in  SCORE_W  binary game score
hi_clear  in  1  single-cycle pulse; clears the high score
bcd_digits  out  4*DIGITS  current score in BCD, digit 0 in [3:0]
hi_digits  out  4*DIGITS  high score in BCD
hi_score  out  SCORE_W  high score in binary (post-saturation value)
blank_mask  out  DIGITS  1 = digit is a leading zero and is blanked
sat  out  1  last converted Score exceeded SAT_MAX
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (asynchronous assert, synchronous release by Clk):
  - all outputs 0, except blank_mask = 6'b111110;
  - FSM enters IDLE; edge-detect register = 0.
- Edge detect: fv_q registers frame_clk. A request is frame_clk & ~fv_q.
  - A request is honoured only in IDLE.
  - Requests arriving in LOAD, SHIFT or DONE are dropped; there is no queue.
- FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: busy=0. On request, go to LOAD next cycle.
  - LOAD:
    - busy=1;
    - bin_q = (Score > SAT_MAX) ? SAT_MAX : Score;
    - sat_q = (Score > SAT_MAX);
    - bcd_q = 0; iter counter = 0.
  - SHIFT: one iteration per cycle.
    - For each digit of bcd_q, add 3 if the digit is >= 5.
    - Then shift {bcd_q, bin_q} left by 1.
    - After SCORE_W iterations (counter = SCORE_W-1 on the last), go to DONE.
  - DONE: for one cycle, done=1 and busy=1. bcd_digits, sat, blank_mask and the high-score registers update on this edge. Then go to IDLE.
- Latency: request seen at cycle N gives LOAD at N+1, SHIFT at N+2..N+21, DONE at N+22. New outputs are visible from N+23.
- Outputs hold their last values between conversions. No glitching during SHIFT; the internal work registers are separate from the outputs.
- Score changing after LOAD has no effect on the conversion in flight.
- blank_mask[i] = 1 iff digit i and all higher digits are 0, for i >= 1. blank_mask[0] is always 0.
- High score: at DONE, if the clamped value > hi_score, then hi_score <= clamped value and hi_digits <= new bcd.
  - Equal values do not update.
- hi_clear: sets hi_score = 0 and hi_digits = 0 at the next edge, in any state.
  - If hi_clear coincides with DONE, the clear wins and the high score is 0 after that edge.
- Reset asserted mid-conversion aborts immediately. Everything returns to reset values; there is no partial output update.
- Arithmetic: digit add-3 is 4-bit and cannot overflow because digits are <= 9 after each shift. The comparator is unsigned at SCORE_W bits. Iteration counter is $clog2(SCORE_W) bits.

Decomposition:
- Package dj_score_pkg:
  - SCORE_W, DIGITS, SAT_MAX constants;
  - typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} score_state_t;
  - typedef logic [4*DIGITS-1:0] bcd_t.
- Sub-module bcd_dabble_step (combinational): takes {bcd, bin}, applies per-digit add-3 and shift-left, returns the next {bcd, bin}. Instantiated once in the FSM datapath.
- Blank-mask generation is a small loop function in the package.

Test Plan:
- Reset with Reset_n=0 mid-SHIFT (Score=777 in flight) -> bcd_digits=0, hi_score=0, busy=0, blank_mask=6'b111110; after release, the next request converts normally.
- Score=0, frame_clk rising at cycle N -> busy high N+1..N+22, done pulse at N+22; bcd_digits=24'h000000, blank_mask=6'b111110, sat=0.
- Score=12345 -> bcd_digits=24'h012345, blank_mask=6'b100000, hi_score=12345, hi_digits=24'h012345.
- Score=20'hFFFFF (1048575) -> bcd_digits=24'h999999, sat=1, hi_score=999999; next Score=5 -> sat=0, bcd_digits=24'h000005, hi_score stays 999999.
- Second frame_clk edge 10 cycles after the first (while busy), with Score changed 500->300 -> only one done pulse, bcd_digits=24'h000500.
- hi_score=500; convert Score=800 with hi_clear pulsed in the DONE cycle -> bcd_digits=24'h000800, hi_score=0, hi_digits=0.
